// File: rtl/heap_overflow_tracker_pkg.sv
// Shared types, constants and helpers for the heap overflow tracker.
package heap_overflow_tracker_pkg;

    localparam int HOT_ADDR_W = 32;

    // Registers used as stack/frame pointers; stores through them are not heap fills.
    localparam logic [4:0] STACK_REG_SP = 5'd2;
    localparam logic [4:0] STACK_REG_FP = 5'd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } hot_state_e;

    typedef struct packed {
        logic [HOT_ADDR_W-1:0] start;
        logic [HOT_ADDR_W-1:0] last;
    } hot_range_t;

    // Store size in bytes, or 0 when the encoding is not a legal SB/SH/SW size.
    function automatic logic [2:0] hot_eff_size(input logic [2:0] size);
        logic [2:0] eff;
        case (size)
            3'd1, 3'd2, 3'd4: eff = size;
            default:          eff = 3'd0;
        endcase
        return eff;
    endfunction

    // True when the base register is the stack or frame pointer.
    function automatic logic hot_is_stack_reg(input logic [4:0] rs1);
        return (rs1 == STACK_REG_SP) || (rs1 == STACK_REG_FP);
    endfunction

endpackage

// File: rtl/heap_overflow_tracker_commit_slot.sv
// One-entry valid/ready holding register. A new entry may be loaded in the
// same cycle the current one is accepted; a load into a full, non-draining
// slot is discarded and reported with a one-cycle drop pulse.
module heap_overflow_tracker_commit_slot #(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_drop;

    logic w_accept;
    logic w_drop;
    logic w_take;

    // Handshake and load/drop decisions for this cycle.
    always_comb begin
        w_accept = r_valid & ready_i;
        w_drop   = load_i & r_valid & ~w_accept;
        w_take   = load_i & ~w_drop;
    end

    // Slot contents: loads win over the clear caused by acceptance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_take) begin
                r_valid <= 1'b1;
                r_data  <= data_i;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_data  <= r_data;
            end else begin
                r_valid <= r_valid;
                r_data  <= r_data;
            end
            r_drop <= w_drop;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign drop_o  = r_drop;

endmodule

// File: rtl/heap_overflow_tracker.sv
// Watches retiring stores for contiguous non-stack fills, commits long runs
// to the range buffer, and raises a crash request when a load that hit a
// tracked range is followed by an indirect jump.
module heap_overflow_tracker
    import heap_overflow_tracker_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int MIN_RUN_BYTES = 32,
    parameter int TIMEOUT       = 10,
    parameter int CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              op_valid_i,
    input  logic              op_is_store_i,
    input  logic              op_is_load_i,
    input  logic              op_is_jalr_i,
    input  logic [2:0]        op_size_i,
    input  logic [4:0]        op_rs1_i,
    input  logic [ADDR_W-1:0] op_addr_i,
    input  logic              flush_i,
    input  logic              crash_en_i,
    input  logic              buf_hit_i,
    output logic              rng_valid_o,
    input  logic              rng_ready_i,
    output logic [ADDR_W-1:0] rng_start_o,
    output logic [ADDR_W-1:0] rng_last_o,
    output logic              active_o,
    output logic              load_in_range_o,
    output logic              crash_o,
    output logic              drop_o
);

    localparam int               TMR_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_RUN_BYTES);

    // Run state
    hot_state_e        r_state;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_next;
    logic [CNT_W-1:0]  r_count;
    logic [TMR_W-1:0]  r_timer;
    logic              r_active;
    logic              r_lir;
    logic              r_crash;

    // Decoded inputs and arithmetic
    logic [2:0]        w_size;
    logic [ADDR_W-1:0] w_size_ext;
    logic              w_tracked;
    logic              w_nonstore;
    logic              w_contig;
    logic [ADDR_W:0]   w_run_sum;
    logic [ADDR_W:0]   w_new_sum;
    logic [CNT_W:0]    w_cnt_sum;
    logic [CNT_W-1:0]  w_cnt_sat;
    logic              w_in_live;
    logic              w_crash;

    // Next-state and close request
    hot_state_e        w_state_nxt;
    logic [ADDR_W-1:0] w_start_nxt;
    logic [ADDR_W-1:0] w_next_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [TMR_W-1:0]  w_timer_nxt;
    logic              w_close;
    logic [ADDR_W-1:0] w_close_start;
    logic [ADDR_W-1:0] w_close_last;
    logic [CNT_W-1:0]  w_close_count;
    logic              w_commit;
    logic [ADDR_W-1:0] w_slot_start;
    logic [ADDR_W-1:0] w_slot_last;

    // Operation decode, address/count arithmetic and load window check.
    always_comb begin
        w_size     = hot_eff_size(op_size_i);
        w_size_ext = ADDR_W'(w_size);
        w_tracked  = op_valid_i & op_is_store_i & (w_size != 3'd0) & ~hot_is_stack_reg(op_rs1_i);
        w_nonstore = op_valid_i & ~op_is_store_i;
        w_contig   = (op_addr_i == r_next);
        w_run_sum  = {1'b0, r_next} + {1'b0, w_size_ext};
        w_new_sum  = {1'b0, op_addr_i} + {1'b0, w_size_ext};
        w_cnt_sum  = {1'b0, r_count} + (CNT_W + 1)'(w_size);
        w_cnt_sat  = w_cnt_sum[CNT_W] ? CNT_MAX : w_cnt_sum[CNT_W-1:0];
        w_in_live  = r_active & (op_addr_i >= r_start) & (op_addr_i < r_next);
        w_crash    = op_valid_i & op_is_jalr_i & r_lir & crash_en_i;
    end

    // Run FSM next state: extend, restart, time out, wrap or flush.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_nxt   = r_start;
        w_next_nxt    = r_next;
        w_count_nxt   = r_count;
        w_timer_nxt   = r_timer;
        w_close       = 1'b0;
        w_close_start = r_start;
        w_close_last  = r_next - ADDR_W'(1);
        w_close_count = r_count;
        if (flush_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_tracked) begin
                        if (w_new_sum[ADDR_W]) begin
                            // A lone store that already wraps cannot form a run.
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = TRACK;
                            w_start_nxt = op_addr_i;
                            w_next_nxt  = w_new_sum[ADDR_W-1:0];
                            w_count_nxt = CNT_W'(w_size);
                            w_timer_nxt = TMR_LOAD;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                TRACK: begin
                    if (w_tracked) begin
                        if (w_contig) begin
                            if (w_run_sum[ADDR_W]) begin
                                // Run reaches the top of memory: close it including this store.
                                w_close       = 1'b1;
                                w_close_last  = w_run_sum[ADDR_W-1:0] - ADDR_W'(1);
                                w_close_count = w_cnt_sat;
                                w_state_nxt   = IDLE;
                            end else begin
                                w_next_nxt  = w_run_sum[ADDR_W-1:0];
                                w_count_nxt = w_cnt_sat;
                                w_timer_nxt = TMR_LOAD;
                            end
                        end else begin
                            // Gap: close the current run and restart from this store.
                            w_close = 1'b1;
                            if (w_new_sum[ADDR_W]) begin
                                w_state_nxt = IDLE;
                            end else begin
                                w_start_nxt = op_addr_i;
                                w_next_nxt  = w_new_sum[ADDR_W-1:0];
                                w_count_nxt = CNT_W'(w_size);
                                w_timer_nxt = TMR_LOAD;
                            end
                        end
                    end else if (w_nonstore) begin
                        if (r_timer == '0) begin
                            w_close     = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_timer_nxt = r_timer - TMR_W'(1);
                        end
                    end else begin
                        w_state_nxt = TRACK;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
        w_commit = w_close & (w_close_count >= CNT_MIN);
    end

    // Run FSM state and run bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_start  <= '0;
            r_next   <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_start  <= w_start_nxt;
            r_next   <= w_next_nxt;
            r_count  <= w_count_nxt;
            r_timer  <= w_timer_nxt;
            r_active <= (w_state_nxt == TRACK);
        end
    end

    // Load hit flag and one-cycle crash request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lir   <= 1'b0;
            r_crash <= 1'b0;
        end else begin
            if (op_valid_i & op_is_load_i) begin
                r_lir <= buf_hit_i | w_in_live;
            end else if (w_crash) begin
                r_lir <= 1'b0;
            end else begin
                r_lir <= r_lir;
            end
            r_crash <= w_crash;
        end
    end

    heap_overflow_tracker_commit_slot #(
        .DATA_W (2 * ADDR_W)
    ) u_commit_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_commit),
        .data_i  ({w_close_start, w_close_last}),
        .ready_i (rng_ready_i),
        .valid_o (rng_valid_o),
        .data_o  ({w_slot_start, w_slot_last}),
        .drop_o  (drop_o)
    );

    assign rng_start_o     = w_slot_start;
    assign rng_last_o      = w_slot_last;
    assign active_o        = r_active;
    assign load_in_range_o = r_lir;
    assign crash_o         = r_crash;

endmodule

// File: tb/tb_heap_overflow_tracker.sv
// Scoreboard bench: a byte-interval reference model predicts every cycle's
// outputs and every committed range; a monitor compares them independently.
module tb_heap_overflow_tracker;
    import heap_overflow_tracker_pkg::*;

    localparam int  MIN_RUN = 32;
    localparam int  TMO     = 10;
    localparam longint TOP  = 64'h1_0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, op_valid_i, op_is_store_i, op_is_load_i, op_is_jalr_i;
    logic [2:0]  op_size_i;
    logic [4:0]  op_rs1_i;
    logic [31:0] op_addr_i;
    logic        flush_i, crash_en_i, buf_hit_i, rng_ready_i;
    logic        rng_valid_o, active_o, load_in_range_o, crash_o, drop_o;
    logic [31:0] rng_start_o, rng_last_o;

    heap_overflow_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_is_store_i(op_is_store_i),
        .op_is_load_i(op_is_load_i), .op_is_jalr_i(op_is_jalr_i), .op_size_i(op_size_i),
        .op_rs1_i(op_rs1_i), .op_addr_i(op_addr_i), .flush_i(flush_i), .crash_en_i(crash_en_i),
        .buf_hit_i(buf_hit_i), .rng_valid_o(rng_valid_o), .rng_ready_i(rng_ready_i),
        .rng_start_o(rng_start_o), .rng_last_o(rng_last_o), .active_o(active_o),
        .load_in_range_o(load_in_range_o), .crash_o(crash_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          active, lir, crash, drop, rvalid;
        logic [31:0] rstart, rlast;
    } exp_t;

    exp_t       exp_q[$];
    hot_range_t exp_rng_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: the live run as a half-open byte interval.
    bit         m_in_run = 0;
    longint     m_start = 0, m_end = 0;
    int         m_bytes = 0, m_quiet = 0;
    bit         m_slot_full = 0;
    hot_range_t m_slot = '0;
    bit         m_lir = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t   e;
        bit     old_active = m_in_run;
        longint os = m_start, oe = m_end;
        longint a, c_s = 0, c_l = 0;
        int     c_b = 0, sz;
        bit     closing = 0, drop = 0, crash = 0, tracked, accept;
        if (rst_i) begin
            m_in_run = 0; m_start = 0; m_end = 0; m_bytes = 0; m_quiet = 0;
            m_slot_full = 0; m_slot = '0; m_lir = 0;
            exp_rng_q.delete();
            e = '{0, 0, 0, 0, 0, 32'h0, 32'h0};
            exp_q.push_back(e);
            return;
        end
        a  = {32'h0, op_addr_i};
        sz = (op_size_i == 3'd1 || op_size_i == 3'd2 || op_size_i == 3'd4) ? int'(op_size_i) : 0;
        tracked = op_valid_i && op_is_store_i && sz != 0 && op_rs1_i != 5'd2 && op_rs1_i != 5'd8;
        accept  = m_slot_full && rng_ready_i;
        if (flush_i) begin
            m_in_run = 0;
        end else if (tracked) begin
            if (m_in_run && a == m_end) begin
                m_bytes = (m_bytes + sz > 65535) ? 65535 : m_bytes + sz;
                m_end   = m_end + sz;
                m_quiet = 0;
                if (m_end >= TOP) begin
                    closing = 1; c_s = m_start; c_l = m_end - 1; c_b = m_bytes; m_in_run = 0;
                end
            end else begin
                if (m_in_run) begin
                    closing = 1; c_s = m_start; c_l = m_end - 1; c_b = m_bytes;
                end
                if (a + sz >= TOP) begin
                    m_in_run = 0;
                end else begin
                    m_in_run = 1; m_start = a; m_end = a + sz; m_bytes = sz; m_quiet = 0;
                end
            end
        end else if (op_valid_i && !op_is_store_i && m_in_run) begin
            if (m_quiet == TMO) begin
                closing = 1; c_s = m_start; c_l = m_end - 1; c_b = m_bytes; m_in_run = 0;
            end else begin
                m_quiet++;
            end
        end
        if (accept) m_slot_full = 0;
        if (closing && c_b >= MIN_RUN) begin
            if (m_slot_full) begin
                drop = 1;
            end else begin
                m_slot_full = 1;
                m_slot.start = c_s[31:0];
                m_slot.last  = c_l[31:0];
                exp_rng_q.push_back(m_slot);
            end
        end
        if (op_valid_i && op_is_load_i) begin
            m_lir = buf_hit_i || (old_active && a >= os && a < oe);
        end else if (op_valid_i && op_is_jalr_i && m_lir && crash_en_i) begin
            crash = 1; m_lir = 0;
        end
        e = '{m_in_run, m_lir, crash, drop, m_slot_full, m_slot.start, m_slot.last};
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: predict, then advance to the next falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk_i);
    endtask

    task automatic drive_op(input bit v, input bit st, input bit ld, input bit jr,
                            input logic [2:0] sz, input logic [4:0] rs, input logic [31:0] ad);
        op_valid_i = v; op_is_store_i = st; op_is_load_i = ld; op_is_jalr_i = jr;
        op_size_i = sz; op_rs1_i = rs; op_addr_i = ad;
        cycle();
    endtask

    task automatic do_store(input logic [31:0] ad, input logic [2:0] sz, input logic [4:0] rs);
        drive_op(1, 1, 0, 0, sz, rs, ad);
    endtask
    task automatic do_alu();             drive_op(1, 0, 0, 0, 3'd0, 5'd0, 32'h0); endtask
    task automatic do_idle();            drive_op(0, 0, 0, 0, 3'd0, 5'd0, 32'h0); endtask
    task automatic do_load(input logic [31:0] ad); drive_op(1, 0, 1, 0, 3'd0, 5'd1, ad); endtask
    task automatic do_jalr();            drive_op(1, 0, 0, 1, 3'd0, 5'd1, 32'h0); endtask

    task automatic sw_run(input logic [31:0] base, input int n, input logic [4:0] rs);
        for (int i = 0; i < n; i++) do_store(base + 32'(4 * i), 3'd4, rs);
    endtask

    // Monitor: per-cycle outputs just after the edge, range handshakes just before it.
    initial begin
        exp_t       e;
        hot_range_t r;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("active_o", 32'(active_o), 32'(e.active));
                chk("load_in_range_o", 32'(load_in_range_o), 32'(e.lir));
                chk("crash_o", 32'(crash_o), 32'(e.crash));
                chk("drop_o", 32'(drop_o), 32'(e.drop));
                chk("rng_valid_o", 32'(rng_valid_o), 32'(e.rvalid));
                if (e.rvalid) begin
                    chk("rng_start_hold", rng_start_o, e.rstart);
                    chk("rng_last_hold", rng_last_o, e.rlast);
                end
            end
            #7;
            if (!rst_i && rng_valid_o === 1'b1 && rng_ready_i === 1'b1) begin
                if (exp_rng_q.size() == 0) begin
                    chk("rng_unexpected", rng_start_o, 32'hFFFF_FFFF);
                end else begin
                    r = exp_rng_q.pop_front();
                    chk("rng_start_accept", rng_start_o, r.start);
                    chk("rng_last_accept", rng_last_o, r.last);
                end
            end
        end
    end

    // Watchdog: the run must never stall.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        logic [31:0] cursor;
        logic [2:0]  sz;
        logic [4:0]  rs;
        int          r;
        rst_i = 1; op_valid_i = 0; op_is_store_i = 0; op_is_load_i = 0; op_is_jalr_i = 0;
        op_size_i = 0; op_rs1_i = 0; op_addr_i = 0; flush_i = 0; crash_en_i = 0;
        buf_hit_i = 0; rng_ready_i = 0;
        @(negedge clk_i);
        cycle(); cycle();
        rst_i = 0;
        chk("reset_active", 32'(active_o), 32'h0);
        chk("reset_valid", 32'(rng_valid_o), 32'h0);
        chk("reset_crash", 32'(crash_o), 32'h0);

        // Eight words, then timeout on the eleventh non-store op; held then accepted.
        sw_run(32'h8000_1000, 8, 5'd10);
        for (int i = 0; i < 10; i++) do_alu();
        chk("t1_active_pre_timeout", 32'(active_o), 32'h1);
        do_alu();
        chk("t1_active_after_timeout", 32'(active_o), 32'h0);
        chk("t1_valid", 32'(rng_valid_o), 32'h1);
        chk("t1_start", rng_start_o, 32'h8000_1000);
        chk("t1_last", rng_last_o, 32'h8000_101F);
        for (int i = 0; i < 3; i++) do_idle();
        chk("t1_start_stable", rng_start_o, 32'h8000_1000);
        rng_ready_i = 1; do_idle(); rng_ready_i = 0;
        chk("t1_valid_cleared", 32'(rng_valid_o), 32'h0);

        // Stack-pointer based stores are not tracked.
        sw_run(32'h8000_1000, 8, 5'd2);
        chk("t2_active", 32'(active_o), 32'h0);
        for (int i = 0; i < 11; i++) do_alu();
        chk("t2_valid", 32'(rng_valid_o), 32'h0);

        // Short byte run, then a gap: no commit, new run live.
        for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(i), 3'd1, 5'd5);
        do_store(32'h200, 3'd4, 5'd5);
        chk("t3_active", 32'(active_o), 32'h1);
        chk("t3_valid", 32'(rng_valid_o), 32'h0);
        flush_i = 1; do_idle(); flush_i = 0;

        // Second qualifying run while the slot is held full.
        sw_run(32'h1000, 8, 5'd10);
        do_store(32'h5000, 3'd4, 5'd10);
        chk("t4_valid", 32'(rng_valid_o), 32'h1);
        sw_run(32'h5004, 7, 5'd10);
        do_store(32'h9000, 3'd4, 5'd10);
        chk("t4_drop", 32'(drop_o), 32'h1);
        chk("t4_old_start", rng_start_o, 32'h1000);
        chk("t4_old_last", rng_last_o, 32'h101F);
        do_idle();
        chk("t4_drop_pulse", 32'(drop_o), 32'h0);
        rng_ready_i = 1; do_idle(); rng_ready_i = 0;
        flush_i = 1; do_idle(); flush_i = 0;

        // Load inside a live run followed by JALR.
        crash_en_i = 1;
        sw_run(32'h8000_2000, 9, 5'd10);
        do_load(32'h8000_2010);
        chk("t5_lir", 32'(load_in_range_o), 32'h1);
        do_jalr();
        chk("t5_crash", 32'(crash_o), 32'h1);
        do_idle();
        chk("t5_crash_pulse", 32'(crash_o), 32'h0);
        chk("t5_lir_cleared", 32'(load_in_range_o), 32'h0);
        crash_en_i = 0;
        do_load(32'h8000_2010);
        do_jalr();
        chk("t5_no_crash", 32'(crash_o), 32'h0);
        chk("t5_lir_kept", 32'(load_in_range_o), 32'h1);
        flush_i = 1; do_idle(); flush_i = 0;
        chk("t5_flush_no_commit", 32'(rng_valid_o), 32'h0);

        // Wrap at the top of memory, flush mid-run, reset mid-handshake.
        do_store(32'hFFFF_FFF8, 3'd4, 5'd10);
        do_store(32'hFFFF_FFFC, 3'd4, 5'd10);
        chk("t6_wrap_active", 32'(active_o), 32'h0);
        sw_run(32'h3000, 8, 5'd10);
        flush_i = 1; do_alu(); flush_i = 0;
        chk("t6_flush_active", 32'(active_o), 32'h0);
        for (int i = 0; i < 11; i++) do_alu();
        chk("t6_flush_valid", 32'(rng_valid_o), 32'h0);
        sw_run(32'h4000, 8, 5'd10);
        do_store(32'h7000, 3'd4, 5'd10);
        chk("t6_pre_reset_valid", 32'(rng_valid_o), 32'h1);
        rst_i = 1; do_idle(); rst_i = 0;
        chk("t6_reset_valid", 32'(rng_valid_o), 32'h0);
        chk("t6_reset_start", rng_start_o, 32'h0);
        chk("t6_reset_active", 32'(active_o), 32'h0);

        // Randomized traffic.
        cursor = 32'h8000_0000;
        for (int n = 0; n < 3000; n++) begin
            rng_ready_i = ($urandom_range(0, 99) < 40);
            crash_en_i  = ($urandom_range(0, 3) != 0);
            buf_hit_i   = ($urandom_range(0, 9) == 0);
            flush_i     = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 99);
            if (r < 55) begin
                case ($urandom_range(0, 6))
                    0: sz = 3'd1;
                    1: sz = 3'd2;
                    5: sz = 3'd3;
                    6: sz = 3'd0;
                    default: sz = 3'd4;
                endcase
                rs = ($urandom_range(0, 99) < 8) ? (($urandom_range(0, 1) == 0) ? 5'd2 : 5'd8) : 5'd10;
                if ($urandom_range(0, 99) < 8) begin
                    if ($urandom_range(0, 9) == 0)
                        cursor = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
                    else
                        cursor = 32'h8000_0000 + 32'($urandom_range(0, 4095) * 4);
                end
                do_store(cursor, sz, rs);
                cursor = cursor + 32'(sz);
            end else if (r < 70) begin
                do_load(cursor - 32'($urandom_range(0, 64)));
            end else if (r < 80) begin
                do_jalr();
            end else if (r < 92) begin
                do_alu();
            end else begin
                do_idle();
            end
        end

        // Drain the commit slot.
        flush_i = 1; rng_ready_i = 1; buf_hit_i = 0;
        do_idle();
        flush_i = 0;
        for (int i = 0; i < 4; i++) do_idle();
        chk("end_exp_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("end_rng_queue_empty", 32'(exp_rng_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
